udp_echo_buffer: RTL and testbench

- Ping-pong payload buffer between the IP/UDP receive stage and the IP frame send stage of the UDP link.
- Captures 32-bit receive words (data_o_valid / ram_wr_data / ram_wr_addr) into one of two 512x32 banks.
- Once a frame completes, hands the bank to the sender: lengths set, tx_start pulsed, words served on ram_rd_addr.
- Bank released on tx_done; frames arriving while both banks are occupied are dropped.

---
 rtl/udp_echo_buffer.sv | 120 ++++++++++++
 tb/tb_udp_echo_buffer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/udp_echo_buffer.sv
// rtl/udp_echo_buffer.sv - ping-pong 2x512x32 UDP payload buffer between receive and send stages
// Optional drop counter enabled by defining UDP_ECHO_DROP_CNT_EN; otherwise drop_cnt reads 0.
module udp_echo_buffer #(
  parameter int          DEPTH_LOG2 = 9,
  parameter logic [15:0] MIN_LEN    = 16'd8,
  parameter logic [15:0] MAX_LEN    = 16'd1472,
  parameter logic [15:0] IP_HDR_LEN = 16'd20
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  data_o_valid,
  input  logic [31:0]           ram_wr_data,
  input  logic [DEPTH_LOG2-1:0] ram_wr_addr,
  input  logic [15:0]           rx_data_length,
  input  logic                  data_receive,
  input  logic [DEPTH_LOG2-1:0] ram_rd_addr,
  output logic [31:0]           ram_rd_data,
  output logic [15:0]           tx_data_length,
  output logic [15:0]           tx_total_length,
  output logic                  tx_start,
  input  logic                  tx_done,
  output logic [1:0]            buf_full,
  output logic [15:0]           drop_cnt
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE, START, SEND, RELEASE} state_t;

  state_t      state, state_next;
  logic [31:0] mem0 [0:DEPTH-1];
  logic [31:0] mem1 [0:DEPTH-1];
  logic [15:0] len0, len1, rlen;
  logic [1:0]  full, full_next;
  logic        wbank, rbank, frame_ok;
  logic        frame_start, wbank_free, wr_en, len_ok, accept, release_bank;

  assign frame_start  = data_o_valid && (ram_wr_addr == '0);
  assign wbank_free   = !full[wbank];
  // The addr-0 word uses the freshly sampled bank state, not the stale frame_ok.
  assign wr_en        = data_o_valid && (frame_start ? wbank_free : frame_ok);
  assign len_ok       = (rx_data_length >= MIN_LEN) && (rx_data_length <= MAX_LEN);
  assign accept       = data_receive && frame_ok && len_ok;
  assign release_bank = (state == RELEASE);
  assign rlen         = rbank ? len1 : len0;
  assign buf_full     = full;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (wbank) mem1[ram_wr_addr] <= ram_wr_data;
      else       mem0[ram_wr_addr] <= ram_wr_data;
    end
    if (accept) begin
      if (wbank) len1 <= rx_data_length;
      else       len0 <= rx_data_length;
    end
  end

  // Release and accept touch different bits whenever both fire.
  always_comb begin
    full_next = full;
    if (release_bank) full_next[rbank] = 1'b0;
    if (accept)       full_next[wbank] = 1'b1;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state           <= IDLE;
      full            <= 2'b00;
      wbank           <= 1'b0;
      rbank           <= 1'b0;
      frame_ok        <= 1'b0;
      tx_data_length  <= 16'd0;
      tx_total_length <= 16'd0;
      ram_rd_data     <= 32'd0;
    end else begin
      state <= state_next;
      full  <= full_next;
      if (data_receive)     frame_ok <= 1'b0;
      else if (frame_start) frame_ok <= wbank_free;
      if (accept)           wbank    <= ~wbank;
      if (release_bank)     rbank    <= ~rbank;
      if (state == IDLE && full[rbank]) begin
        tx_data_length  <= rlen;
        tx_total_length <= rlen + IP_HDR_LEN;
      end
      ram_rd_data <= rbank ? mem1[ram_rd_addr] : mem0[ram_rd_addr];
    end
  end

  always_comb begin
    state_next = state;
    tx_start   = 1'b0;
    case (state)
      IDLE:    if (full[rbank]) state_next = START;
      START: begin
        tx_start   = 1'b1;
        state_next = SEND;
      end
      SEND:    if (tx_done) state_next = RELEASE;
      RELEASE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

`ifdef UDP_ECHO_DROP_CNT_EN
  logic        drop;
  logic [15:0] drop_q;

  assign drop     = data_receive && !accept;
  assign drop_cnt = drop_q;

  always_ff @(posedge clk or posedge clr) begin
    if (clr)                               drop_q <= 16'd0;
    else if (drop && drop_q != 16'hFFFF)   drop_q <= drop_q + 16'd1;
  end
`else
  assign drop_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_udp_echo_buffer.sv
// tb/tb_udp_echo_buffer.sv - self-checking bench for udp_echo_buffer
module tb_udp_echo_buffer;
  logic        clk = 1'b0;
  logic        clr;
  logic        data_o_valid;
  logic [31:0] ram_wr_data;
  logic [8:0]  ram_wr_addr;
  logic [15:0] rx_data_length;
  logic        data_receive;
  logic [8:0]  ram_rd_addr;
  logic [31:0] ram_rd_data;
  logic [15:0] tx_data_length;
  logic [15:0] tx_total_length;
  logic        tx_start;
  logic        tx_done;
  logic [1:0]  buf_full;
  logic [15:0] drop_cnt;

  udp_echo_buffer dut (
    .clk(clk), .clr(clr), .data_o_valid(data_o_valid), .ram_wr_data(ram_wr_data),
    .ram_wr_addr(ram_wr_addr), .rx_data_length(rx_data_length), .data_receive(data_receive),
    .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data), .tx_data_length(tx_data_length),
    .tx_total_length(tx_total_length), .tx_start(tx_start), .tx_done(tx_done),
    .buf_full(buf_full), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] len;
    int          nwords;
    bit          pat;
  } frame_t;

  typedef struct {
    logic [15:0] len;
    int          nwords;
    bit          pat;
    bit          accept;
  } vec_t;

  frame_t sb[$];
  int     tests = 0;
  int     fails = 0;
  int     starts_seen = 0;
  int     starts_served = 0;
  int     exp_drop = 0;
  bit     exp_wbank = 1'b0;

  always @(negedge clk) if (tx_start === 1'b1) starts_seen++;

  function automatic logic [31:0] word_of(input logic [15:0] len, input int i, input bit pat);
    if (pat) return 32'(32'h11111111 * (i + 1));
    return {len ^ 16'hC3A5, 16'(i * 7 + 3)};
  endfunction

  function automatic logic [15:0] exp_drop_val();
`ifdef UDP_ECHO_DROP_CNT_EN
    return 16'(exp_drop);
`else
    return 16'd0;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [15:0] len, input int n, input bit pat, input bit accept);
    frame_t f;
    for (int i = 0; i < n; i++) begin
      step();
      data_o_valid = 1'b1;
      ram_wr_addr  = 9'(i);
      ram_wr_data  = word_of(len, i, pat);
    end
    step();
    data_o_valid   = 1'b0;
    rx_data_length = len;
    data_receive   = 1'b1;
    step();
    data_receive   = 1'b0;
    if (accept) begin
      f.len = len; f.nwords = n; f.pat = pat;
      sb.push_back(f);
      exp_wbank = ~exp_wbank;
    end else begin
      exp_drop++;
    end
  endtask

  task automatic wait_start(output bit got);
    got = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (starts_seen > starts_served) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("tx_start_seen", {31'd0, got}, 32'd1);
  endtask

  task automatic serve_frame(input logic [1:0] full_after);
    frame_t e;
    bit     got;
    wait_start(got);
    if (!got) return;
    starts_served++;
    if (sb.size() == 0) begin
      check("scoreboard_nonempty", 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    check("tx_data_length", {16'd0, tx_data_length}, {16'd0, e.len});
    check("tx_total_length", {16'd0, tx_total_length}, {16'd0, e.len + 16'd20});
    for (int i = 0; i < e.nwords; i++) begin
      ram_rd_addr = 9'(i);
      @(posedge clk);
      #1;
      check("rd_word", ram_rd_data, word_of(e.len, i, e.pat));
    end
    check("tx_start_single", {31'd0, tx_start}, 32'd0);
    check("no_extra_start", 32'(starts_seen - starts_served), 32'd0);
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    step();
    check("buf_full_release", {30'd0, buf_full}, {30'd0, full_after});
  endtask

  initial begin
    vec_t       vecs[9];
    logic [1:0] exp_full;
    bit         wb0;
    bit         got;

    vecs[0] = '{16'd16,   4,   1'b1, 1'b1};
    vecs[1] = '{16'd8,    2,   1'b0, 1'b1};
    vecs[2] = '{16'd7,    2,   1'b0, 1'b0};
    vecs[3] = '{16'd1472, 368, 1'b0, 1'b1};
    vecs[4] = '{16'd1473, 4,   1'b0, 1'b0};
    vecs[5] = '{16'd4,    1,   1'b0, 1'b0};
    vecs[6] = '{16'd1500, 4,   1'b0, 1'b0};
    vecs[7] = '{16'd16,   0,   1'b0, 1'b0};
    vecs[8] = '{16'd12,   3,   1'b0, 1'b1};

    clr = 1'b1; data_o_valid = 1'b0; ram_wr_data = '0; ram_wr_addr = '0;
    rx_data_length = '0; data_receive = 1'b0; ram_rd_addr = '0; tx_done = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_buf_full", {30'd0, buf_full}, 32'd0);
    check("rst_tx_start", {31'd0, tx_start}, 32'd0);
    check("rst_tx_data_length", {16'd0, tx_data_length}, 32'd0);
    check("rst_tx_total_length", {16'd0, tx_total_length}, 32'd0);
    check("rst_ram_rd_data", ram_rd_data, 32'd0);
    check("rst_drop_cnt", {16'd0, drop_cnt}, 32'd0);
    clr = 1'b0;
    step();

    for (int v = 0; v < 9; v++) begin
      exp_full = vecs[v].accept ? (exp_wbank ? 2'b10 : 2'b01) : 2'b00;
      send_frame(vecs[v].len, vecs[v].nwords, vecs[v].pat, vecs[v].accept);
      check("vec_buf_full", {30'd0, buf_full}, {30'd0, exp_full});
      check("vec_drop_cnt", {16'd0, drop_cnt}, {16'd0, exp_drop_val()});
      if (vecs[v].accept) serve_frame(2'b00);
    end

    wb0 = exp_wbank;
    send_frame(16'd12, 3, 1'b0, 1'b1);
    send_frame(16'd20, 5, 1'b0, 1'b1);
    check("pp_buf_full", {30'd0, buf_full}, 32'd3);
    repeat (5) step();
    check("pp_one_start", 32'(starts_seen - starts_served), 32'd1);
    send_frame(16'd24, 6, 1'b0, 1'b0);
    check("ovf_buf_full", {30'd0, buf_full}, 32'd3);
    check("ovf_drop_cnt", {16'd0, drop_cnt}, {16'd0, exp_drop_val()});
    send_frame(16'd4, 0, 1'b0, 1'b0);
    send_frame(16'd1500, 0, 1'b0, 1'b0);
    check("len_buf_full", {30'd0, buf_full}, 32'd3);
    check("len_drop_cnt", {16'd0, drop_cnt}, {16'd0, exp_drop_val()});
    serve_frame(wb0 ? 2'b01 : 2'b10);
    serve_frame(2'b00);

    send_frame(16'd16, 4, 1'b0, 1'b1);
    wait_start(got);
    repeat (2) @(negedge clk);
    clr = 1'b1;
    #1;
    check("mid_rst_buf_full", {30'd0, buf_full}, 32'd0);
    check("mid_rst_tx_start", {31'd0, tx_start}, 32'd0);
    check("mid_rst_tx_data_length", {16'd0, tx_data_length}, 32'd0);
    check("mid_rst_tx_total_length", {16'd0, tx_total_length}, 32'd0);
    check("mid_rst_ram_rd_data", ram_rd_data, 32'd0);
    check("mid_rst_drop_cnt", {16'd0, drop_cnt}, 32'd0);
    sb.delete();
    starts_served = starts_seen;
    exp_wbank = 1'b0;
    exp_drop = 0;
    @(negedge clk);
    clr = 1'b0;
    send_frame(16'd20, 5, 1'b0, 1'b1);
    check("post_rst_buf_full", {30'd0, buf_full}, 32'd1);
    serve_frame(2'b00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
